// File: rtl/imem_loader.sv
// Boot-time loader that streams 32-bit words into the instruction SRAM pair
// and holds the core in reset while the load session runs.
module imem_loader #(
    parameter int WE_CYCLES = 2,
    parameter int ADDR_W    = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   word_count,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_data,
    output logic              busy,
    output logic              cpu_hold,
    output logic              done,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_ce_n,
    output logic              ram_oe_n,
    output logic              ram_we_n,
    output logic              ram_bhe_n,
    output logic              ram_ble_n,
    inout  wire  [31:0]       ram_data
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ACCEPT,
        S_SETUP,
        S_PULSE,
        S_HOLD,
        S_FIN
    } state_t;

    localparam logic [3:0] PULSE_LAST = 4'(WE_CYCLES - 1);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W:0]   remain_q, remain_d;
    logic [31:0]       data_q, data_d;
    logic [3:0]        pulse_cnt_q, pulse_cnt_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              in_ready_q, in_ready_d;
    logic              ce_n_q, ce_n_d;
    logic              we_n_q, we_n_d;
    logic              drive_q, drive_d;

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        remain_d    = remain_q;
        data_d      = data_q;
        pulse_cnt_d = pulse_cnt_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    addr_d   = base_addr;
                    remain_d = word_count;
                    state_d  = (word_count == '0) ? S_FIN : S_ACCEPT;
                end
            end
            S_ACCEPT: begin
                if (in_valid && in_ready_q) begin
                    data_d  = in_data;
                    state_d = S_SETUP;
                end
            end
            S_SETUP: begin
                pulse_cnt_d = PULSE_LAST;
                state_d     = S_PULSE;
            end
            S_PULSE: begin
                if (pulse_cnt_q == 4'd0) begin
                    state_d = S_HOLD;
                end else begin
                    pulse_cnt_d = pulse_cnt_q - 4'd1;
                end
            end
            S_HOLD: begin
                // Address advances only on HOLD exit, so it never moves under a low we_n.
                remain_d = remain_q - 1'b1;
                addr_d   = addr_q + 1'b1;
                state_d  = (remain_q == (ADDR_W+1)'(1)) ? S_FIN : S_ACCEPT;
            end
            S_FIN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Pin controls are decoded from the next state and registered, so they are glitch-free.
        busy_d     = (state_d != S_IDLE);
        done_d     = (state_d == S_FIN);
        in_ready_d = (state_d == S_ACCEPT);
        we_n_d     = (state_d != S_PULSE);
        drive_d    = (state_d == S_SETUP) || (state_d == S_PULSE) || (state_d == S_HOLD);
        ce_n_d     = !((state_d == S_ACCEPT) || drive_d);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            remain_q    <= '0;
            data_q      <= '0;
            pulse_cnt_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            in_ready_q  <= 1'b0;
            ce_n_q      <= 1'b1;
            we_n_q      <= 1'b1;
            drive_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            remain_q    <= remain_d;
            data_q      <= data_d;
            pulse_cnt_q <= pulse_cnt_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            in_ready_q  <= in_ready_d;
            ce_n_q      <= ce_n_d;
            we_n_q      <= we_n_d;
            drive_q     <= drive_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign busy      = busy_q;
    assign cpu_hold  = busy_q;
    assign done      = done_q;
    assign ram_addr  = addr_q;
    assign ram_ce_n  = ce_n_q;
    assign ram_oe_n  = 1'b1;
    assign ram_we_n  = we_n_q;
    assign ram_bhe_n = ~busy_q;
    assign ram_ble_n = ~busy_q;
    assign ram_data  = drive_q ? data_q : {32{1'bz}};

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: table of load sessions checked against an SRAM
// model, plus reset-in-pulse and bus-ownership sequences.
module tb_imem_loader;

    localparam int WE = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] base_addr;
    logic [16:0] word_count;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        busy;
    logic        cpu_hold;
    logic        done;
    logic [15:0] ram_addr;
    logic        ram_ce_n;
    logic        ram_oe_n;
    logic        ram_we_n;
    logic        ram_bhe_n;
    logic        ram_ble_n;
    wire  [31:0] ram_data;

    logic        tb_drv_en;
    logic [31:0] tb_drv_val;
    assign ram_data = tb_drv_en ? tb_drv_val : {32{1'bz}};

    int n_vec = 0;
    int n_err = 0;

    imem_loader #(.WE_CYCLES(WE), .ADDR_W(16)) dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
        .word_count(word_count), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .busy(busy), .cpu_hold(cpu_hold), .done(done),
        .ram_addr(ram_addr), .ram_ce_n(ram_ce_n), .ram_oe_n(ram_oe_n),
        .ram_we_n(ram_we_n), .ram_bhe_n(ram_bhe_n), .ram_ble_n(ram_ble_n),
        .ram_data(ram_data)
    );

    always #5 clk = ~clk;

    // SRAM model: the word is latched on the rising edge of we_n.
    logic [31:0] mem [0:65535];
    int          wr_count = 0;
    always @(posedge ram_we_n) begin
        if (!rst) begin
            mem[ram_addr] <= ram_data;
            wr_count      <= wr_count + 1;
        end
    end

    typedef struct {
        logic [15:0] base;
        logic [16:0] count;
        logic [31:0] seed;
        int          stall_word;
        int          stall_cyc;
        int          ign_at;
        int          lat;
    } vec_t;

    vec_t vecs [5];

    function automatic logic [31:0] word_of(input logic [31:0] seed, input int i);
        return seed ^ (32'(i) * 32'h0101_0101);
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end else begin
            $display("ok   %s: %0h", name, act);
        end
    endtask

    // Drive a pattern from the bench side; it reads back intact only if the DUT is not driving.
    task automatic probe_bus(input string name);
        tb_drv_val = 32'h3C5A_A5C3;
        tb_drv_en  = 1'b1;
        #1;
        chk(name, ram_data, 32'h3C5A_A5C3);
        tb_drv_en  = 1'b0;
        #1;
    endtask

    task automatic run_vec(input vec_t v);
        int          sent, stall_left, runs, low_len, done_seen, done_k, wr_before;
        logic        hs, prev_we;
        logic [15:0] prev_addr, exp_addr;
        logic [31:0] prev_data;

        wr_before = wr_count;
        @(negedge clk);
        start      = 1'b1;
        base_addr  = v.base;
        word_count = v.count;
        in_valid   = (v.count != 17'd0);
        in_data    = word_of(v.seed, 0);
        sent = 0; stall_left = 0; runs = 0; low_len = 0; done_seen = 0; done_k = -1;
        prev_we = ram_we_n; prev_addr = ram_addr; prev_data = ram_data;

        for (int k = 0; k < 200 && !(done_k >= 0 && k > done_k + 2); k++) begin
            hs = in_valid && in_ready;
            @(posedge clk);
            #1;
            if (done) begin
                done_seen++;
                if (done_k < 0) done_k = k;
            end
            exp_addr = v.base + 16'(runs);
            if (!ram_we_n) begin
                if (prev_we) begin
                    chk("setup_addr_stable", prev_addr, ram_addr);
                    chk("setup_data_stable", prev_data, ram_data);
                    chk("pulse_addr", ram_addr, exp_addr);
                    chk("pulse_data", ram_data, word_of(v.seed, runs));
                end
                low_len++;
            end else if (!prev_we) begin
                chk("pulse_width", low_len, WE);
                chk("hold_addr_stable", ram_addr, prev_addr);
                chk("hold_data_stable", ram_data, prev_data);
                runs++;
                low_len = 0;
            end
            prev_we = ram_we_n; prev_addr = ram_addr; prev_data = ram_data;

            @(negedge clk);
            start      = (k + 1 == v.ign_at);
            base_addr  = 16'h0300;
            word_count = 17'd5;
            if (hs) begin
                sent++;
                if (sent == v.stall_word) stall_left = v.stall_cyc;
            end
            if (stall_left > 0) begin
                in_valid = 1'b0;
                if (in_ready) begin
                    chk("stall_we_n", ram_we_n, 1'b1);
                    stall_left--;
                end
            end else begin
                in_valid = (sent < int'(v.count));
                in_data  = word_of(v.seed, sent);
            end
        end
        start    = 1'b0;
        in_valid = 1'b0;

        chk("done_count", done_seen, 1);
        chk("latency", done_k + 2, v.lat);
        chk("pulse_runs", runs, v.count);
        chk("write_count", wr_count - wr_before, v.count);
        chk("busy_after", busy, 1'b0);
        chk("oe_n_after", ram_oe_n, 1'b1);
        for (int i = 0; i < int'(v.count); i++) begin
            chk("mem_word", mem[v.base + 16'(i)], word_of(v.seed, i));
        end
        probe_bus("bus_hiz_after");
    endtask

    initial begin
        vec_t rv;
        logic found;

        vecs[0] = '{16'h0010, 17'd1, 32'hDEAD_BEEF, -1, 0, -1, 7};
        vecs[1] = '{16'h0100, 17'd4, 32'h1000_0001,  2, 3, -1, 25};
        vecs[2] = '{16'hFFFE, 17'd3, 32'hCAFE_0000, -1, 0, -1, 17};
        vecs[3] = '{16'h1234, 17'd0, 32'h0000_0000, -1, 0, -1, 2};
        vecs[4] = '{16'h0200, 17'd2, 32'h55AA_0000, -1, 0,  3, 12};

        rst = 1'b1; start = 1'b0; base_addr = '0; word_count = '0;
        in_valid = 1'b0; in_data = '0; tb_drv_en = 1'b0; tb_drv_val = '0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", busy, 1'b0);
        chk("rst_cpu_hold", cpu_hold, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_in_ready", in_ready, 1'b0);
        chk("rst_ce_n", ram_ce_n, 1'b1);
        chk("rst_we_n", ram_we_n, 1'b1);
        chk("rst_oe_n", ram_oe_n, 1'b1);
        chk("rst_bhe_n", ram_bhe_n, 1'b1);
        chk("rst_ble_n", ram_ble_n, 1'b1);
        chk("rst_addr", ram_addr, 16'h0000);
        probe_bus("rst_bus_hiz");
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 5; i++) begin
            run_vec(vecs[i]);
            if (i == 0) begin
                tb_drv_val = mem[16'h0010];
                tb_drv_en  = 1'b1;
                #1;
                chk("fetch_read", ram_data, 32'hDEAD_BEEF);
                tb_drv_en  = 1'b0;
                #1;
            end
        end
        chk("wrap_word_0000", mem[16'h0000], word_of(32'hCAFE_0000, 2));

        // Reset asserted in the middle of a write pulse.
        @(negedge clk);
        start = 1'b1; base_addr = 16'h0400; word_count = 17'd2;
        in_valid = 1'b1; in_data = 32'h0BAD_F00D;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(posedge clk);
            #1;
            start = 1'b0;
            if (!ram_we_n) found = 1'b1;
        end
        chk("rst_pulse_reached", found, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        chk("async_we_n", ram_we_n, 1'b1);
        chk("async_busy", busy, 1'b0);
        chk("async_cpu_hold", cpu_hold, 1'b0);
        chk("async_ce_n", ram_ce_n, 1'b1);
        probe_bus("async_bus_hiz");
        @(negedge clk);
        rst = 1'b0; in_valid = 1'b0;

        rv = '{16'h0400, 17'd2, 32'h7777_0000, -1, 0, -1, 12};
        run_vec(rv);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time writer for the instruction SRAM pair (two 16-bit CY7C1021 parts forming a 32-bit word) that the fetch stage reads. Accepts 32-bit words over a valid/ready stream, writes them to consecutive word addresses with a controlled write-enable pulse, and holds the core in reset while the load runs. While `busy` is high, this block owns the SRAM address, control and data pins; the fetch-side address mux selects it via `busy`.

## Interface

- `WE_CYCLES`, 2: width of the `ram_we_n` low pulse in clocks; legal range 1–15.
- `ADDR_W`, 16: SRAM word-address width. This is `currPc[17:2]` on the fetch side.

- `clk`  in  1  single clock; all state updates on the rising edge
- `rst`  in  1  asynchronous, active-high reset
- `start`  in  1  one-cycle request to begin a load session; sampled only in IDLE
- `base_addr`  in  ADDR_W  first word address; captured on accepted `start`
- `word_count`  in  ADDR_W+1  number of words to write, 0..2^ADDR_W; captured on accepted `start`
- `in_valid`  in  1  `in_data` holds a word
- `in_ready`  out  1  block accepts a word this cycle
- `in_data`  in  32  word to write
- `busy`  out  1  session active; selects this block on the SRAM pin mux
- `cpu_hold`  out  1  core reset request; equals `busy`
- `done`  out  1  one-cycle pulse when a session completes
- `ram_addr`  out  ADDR_W  SRAM word address
- `ram_ce_n`  out  1  chip enable, active low
- `ram_oe_n`  out  1  output enable, active low; always 1 from this block
- `ram_we_n`  out  1  write enable, active low
- `ram_bhe_n`, `ram_ble_n`  out  1 each  byte enables; 0 while `busy`, else 1
- `ram_data`  inout  32  driven only in SETUP, PULSE and HOLD; high-Z otherwise

## Operation

- **States:** IDLE, ACCEPT, SETUP, PULSE, HOLD, FIN.
- **IDLE:** all SRAM outputs are inactive (`ram_ce_n`=`ram_we_n`=`ram_oe_n`=1) and the data bus is high-Z.
  - On `start`, capture `base_addr` into the address register and `word_count` into the remaining counter.
  - If the count is 0, go to FIN. Otherwise go to ACCEPT.
- **ACCEPT:**
  - `in_ready`=1 and `ram_ce_n`=0.
  - When `in_valid`&&`in_ready`, latch `in_data` into the data register and go to SETUP.
  - Otherwise stay in ACCEPT for as long as it takes; there is no timeout.
- **SETUP (1 cycle):** address and data are stable and driven, `ram_we_n`=1.
- **PULSE (WE_CYCLES cycles):** `ram_we_n`=0. Address and data are unchanged.
- **HOLD (1 cycle):**
  - `ram_we_n`=1. Data is still driven and the address is unchanged (hold time).
  - Then decrement the remaining counter and increment the address modulo 2^ADDR_W.
  - Go to ACCEPT if the remaining count is nonzero after the decrement, else FIN.
- **FIN (1 cycle):** `done`=1, `busy` drops to 0 the following cycle, then return to IDLE.
- **Address wrap:** address 2^ADDR_W−1 is followed by 0. There is no error indication.
- `start` outside IDLE is ignored. `word_count` and `base_addr` changes after capture have no effect.
- `ram_we_n` and the data-drive enable come directly from registered state (glitch-free). The address never changes while `ram_we_n`=0.

## Timing

- **Reset values:** state IDLE, `busy`=`cpu_hold`=0, `done`=0, `in_ready`=0, `ram_ce_n`=`ram_we_n`=`ram_oe_n`=`ram_bhe_n`=`ram_ble_n`=1, `ram_addr`=0, data bus high-Z.
- **Reset mid-operation:** `rst` asserted in any state (including PULSE) forces `ram_we_n`=1 and releases the bus asynchronously, with no wait for a clock edge. The partially written word is undefined.
- **`busy`:** rises the cycle after the accepted `start` and stays high through FIN.
- **Per-word throughput:** 3+WE_CYCLES cycles (accept, setup, pulse, hold) when `in_valid` is held high. This is 5 cycles at the default.
- **Session latency:** from `start` to `done` is 1 + N·(3+WE_CYCLES) + 1 cycles with no source stalls. For N=0 it is 2 cycles (IDLE→FIN, `done` on the second cycle).
- `in_ready` is never high outside ACCEPT, so at most one word is buffered.

## Test plan

- **Single word:** reset, then `start` with base 0x0010, count 1, and in_data 0xDEADBEEF valid immediately.
  - SRAM model word 0x0010 = 0xDEADBEEF.
  - `ram_we_n` low exactly 2 cycles, with address and data stable 1 cycle before and after.
  - `done` 1 cycle, 7 cycles after `start`.
- **Burst with stalls:** base 0x0100, count 4, source deasserts `in_valid` for 3 cycles before word 3.
  - Words 0x0100–0x0103 are correct.
  - The block waits in ACCEPT with `ram_we_n`=1 during the stall.
- **Wrap and zero count:**
  - base 0xFFFE, count 3 → writes land at 0xFFFE, 0xFFFF, 0x0000.
  - Separate session with count 0 → `done` after 2 cycles, no `ram_we_n` activity.
- **Reset in PULSE:** assert `rst` mid-pulse → `ram_we_n`=1, data bus high-Z, and `busy`=0 in the same cycle (before any edge). A later session works normally.
- **Ignored start:** pulse `start` with different arguments during a 2-word session → only the original session's addresses are written, exactly one `done`.
- **Bus ownership:** in IDLE and after `done`, `ram_data` is high-Z and `ram_oe_n`=1.
  - A fetch-side read of the loaded address returns the written word with no contention (no X on the bus).
